// File: rtl/pipe_defs.sv
// Shared encodings for the execute stage: ALU ops, mul/div ops and the EX/MEM bundle.
package pipe_defs;

  localparam logic [3:0] ALUC_ADD  = 4'd0;
  localparam logic [3:0] ALUC_SUB  = 4'd1;
  localparam logic [3:0] ALUC_AND  = 4'd2;
  localparam logic [3:0] ALUC_OR   = 4'd3;
  localparam logic [3:0] ALUC_XOR  = 4'd4;
  localparam logic [3:0] ALUC_LUI  = 4'd5;
  localparam logic [3:0] ALUC_SLL  = 4'd6;
  localparam logic [3:0] ALUC_SRL  = 4'd7;
  localparam logic [3:0] ALUC_SRA  = 4'd8;
  localparam logic [3:0] ALUC_SLT  = 4'd9;
  localparam logic [3:0] ALUC_SLTU = 4'd10;
  localparam logic [3:0] ALUC_NOR  = 4'd11;

  localparam logic [2:0] MDOP_NONE  = 3'd0;
  localparam logic [2:0] MDOP_MULT  = 3'd1;
  localparam logic [2:0] MDOP_MULTU = 3'd2;
  localparam logic [2:0] MDOP_DIV   = 3'd3;
  localparam logic [2:0] MDOP_DIVU  = 3'd4;
  localparam logic [2:0] MDOP_MFHI  = 3'd5;
  localparam logic [2:0] MDOP_MFLO  = 3'd6;

  typedef struct packed {
    logic        wreg;
    logic        m2reg;
    logic        wmem;
    logic [4:0]  wn;
    logic [31:0] alu_result;
    logic [31:0] di;
  } ex_mem_t;

  localparam ex_mem_t EX_MEM_BUBBLE = '0;

  function automatic logic is_md_start(input logic [2:0] op);
    return (op >= MDOP_MULT) && (op <= MDOP_DIVU);
  endfunction

  // Anything that either occupies the MDU or reads HI/LO.
  function automatic logic is_md_dep(input logic [2:0] op);
    return (op >= MDOP_MULT) && (op <= MDOP_MFLO);
  endfunction

endpackage

// File: rtl/ex_muldiv.sv
// Iterative multiply/divide unit: shift-add multiply, restoring divide, sign fix-up at the end.
// state | meaning:  ST_IDLE | waiting for start, HI/LO stable;  ST_BUSY | one iteration per cycle
module ex_muldiv
  import pipe_defs::*;
#(
  parameter int MD_CYCLES = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int CW = (MD_CYCLES > 1) ? $clog2(MD_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(MD_CYCLES - 1);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  logic [0:0]    state;
  logic [CW-1:0] count;
  logic [31:0]   hi_acc, lo_acc, mcand, a_raw;
  logic          is_div, neg_q, neg_r, div_zero;

  logic          signed_op;
  logic [31:0]   abs_a, abs_b;
  logic [32:0]   mul_sum, div_shift, div_diff;
  logic [31:0]   hi_step, lo_step, hi_fin, lo_fin;
  logic [63:0]   prod, prod_s;

  assign busy      = (state == ST_BUSY);
  assign signed_op = (op == MDOP_MULT) || (op == MDOP_DIV);
  assign abs_a     = (signed_op && a[31]) ? -a : a;
  assign abs_b     = (signed_op && b[31]) ? -b : b;

  always_comb begin
    mul_sum   = lo_acc[0] ? ({1'b0, hi_acc} + {1'b0, mcand}) : {1'b0, hi_acc};
    div_shift = {hi_acc, lo_acc[31]};
    div_diff  = div_shift - {1'b0, mcand};
    hi_step   = mul_sum[32:1];
    lo_step   = {mul_sum[0], lo_acc[31:1]};
    if (is_div) begin
      if (!div_diff[32]) begin
        hi_step = div_diff[31:0];
        lo_step = {lo_acc[30:0], 1'b1};
      end else begin
        hi_step = div_shift[31:0];
        lo_step = {lo_acc[30:0], 1'b0};
      end
    end
  end

  // Final step result with sign correction; divide-by-zero bypasses the datapath.
  always_comb begin
    prod   = {hi_step, lo_step};
    prod_s = neg_q ? -prod : prod;
    hi_fin = prod_s[63:32];
    lo_fin = prod_s[31:0];
    if (is_div) begin
      if (div_zero) begin
        hi_fin = a_raw;
        lo_fin = 32'hFFFF_FFFF;
      end else begin
        hi_fin = neg_r ? -hi_step : hi_step;
        lo_fin = neg_q ? -lo_step : lo_step;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      count    <= '0;
      hi       <= '0;
      lo       <= '0;
      hi_acc   <= '0;
      lo_acc   <= '0;
      mcand    <= '0;
      a_raw    <= '0;
      is_div   <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      div_zero <= 1'b0;
    end else if (state == ST_IDLE) begin
      if (start) begin
        state    <= ST_BUSY;
        count    <= '0;
        hi_acc   <= '0;
        lo_acc   <= abs_a;
        mcand    <= abs_b;
        a_raw    <= a;
        is_div   <= (op == MDOP_DIV) || (op == MDOP_DIVU);
        neg_q    <= signed_op && (a[31] ^ b[31]);
        neg_r    <= signed_op && a[31];
        div_zero <= (b == 32'd0);
      end
    end else begin
      hi_acc <= hi_step;
      lo_acc <= lo_step;
      if (count == LAST) begin
        hi    <= hi_fin;
        lo    <= lo_fin;
        state <= ST_IDLE;
      end else begin
        count <= count + 1'b1;
      end
    end
  end

endmodule

// File: rtl/pipe_ex.sv
// Execute stage: single-cycle ALU, iterative MDU with HI/LO, and the EX/MEM pipeline register.
module pipe_ex
  import pipe_defs::*;
#(
  parameter int MD_CYCLES = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        EXwreg,
  input  logic        EXm2reg,
  input  logic        EXwmem,
  input  logic [4:0]  EXwn,
  input  logic [3:0]  EXaluc,
  input  logic        EXaluimm,
  input  logic        EXshift,
  input  logic [2:0]  EXmdop,
  input  logic [31:0] EXa,
  input  logic [31:0] EXb,
  input  logic [31:0] EXimm,
  output logic        EXstall,
  output logic        MEMwreg,
  output logic        MEMm2reg,
  output logic        MEMwmem,
  output logic [4:0]  MEMwn,
  output logic [31:0] MEMaluResult,
  output logic [31:0] MEMdi
);

  logic [31:0] op_a, op_b, alu_y, ex_result;
  logic        md_busy, md_start;
  logic [31:0] md_hi, md_lo;
  ex_mem_t     ex_mem_d, ex_mem_q;

  assign op_a = EXshift ? {27'b0, EXimm[10:6]} : EXa;
  assign op_b = EXaluimm ? EXimm : EXb;

  always_comb begin
    alu_y = '0;
    case (EXaluc)
      ALUC_ADD:  alu_y = op_a + op_b;
      ALUC_SUB:  alu_y = op_a - op_b;
      ALUC_AND:  alu_y = op_a & op_b;
      ALUC_OR:   alu_y = op_a | op_b;
      ALUC_XOR:  alu_y = op_a ^ op_b;
      ALUC_LUI:  alu_y = {op_b[15:0], 16'b0};
      ALUC_SLL:  alu_y = op_b << op_a[4:0];
      ALUC_SRL:  alu_y = op_b >> op_a[4:0];
      ALUC_SRA:  alu_y = $unsigned($signed(op_b) >>> op_a[4:0]);
      ALUC_SLT:  alu_y = {31'b0, $signed(op_a) < $signed(op_b)};
      ALUC_SLTU: alu_y = {31'b0, op_a < op_b};
      ALUC_NOR:  alu_y = ~(op_a | op_b);
      default:   alu_y = '0;
    endcase
  end

  // Only dependents of the MDU wait; independent ALU ops flow while it iterates.
  assign EXstall  = md_busy && is_md_dep(EXmdop);
  assign md_start = is_md_start(EXmdop) && !EXstall;

  ex_muldiv #(.MD_CYCLES(MD_CYCLES)) u_muldiv (
    .clk   (clk),
    .rst   (rst),
    .start (md_start),
    .op    (EXmdop),
    .a     (EXa),
    .b     (EXb),
    .busy  (md_busy),
    .hi    (md_hi),
    .lo    (md_lo)
  );

  always_comb begin
    ex_result = alu_y;
    if (EXmdop == MDOP_MFHI) ex_result = md_hi;
    else if (EXmdop == MDOP_MFLO) ex_result = md_lo;
  end

  always_comb begin
    ex_mem_d.wreg       = EXwreg;
    ex_mem_d.m2reg      = EXm2reg;
    ex_mem_d.wmem       = EXwmem;
    ex_mem_d.wn         = EXwn;
    ex_mem_d.alu_result = ex_result;
    ex_mem_d.di         = EXb;
  end

  always_ff @(posedge clk) begin
    if (rst || EXstall) ex_mem_q <= EX_MEM_BUBBLE;
    else                ex_mem_q <= ex_mem_d;
  end

  assign MEMwreg      = ex_mem_q.wreg;
  assign MEMm2reg     = ex_mem_q.m2reg;
  assign MEMwmem      = ex_mem_q.wmem;
  assign MEMwn        = ex_mem_q.wn;
  assign MEMaluResult = ex_mem_q.alu_result;
  assign MEMdi        = ex_mem_q.di;

endmodule

// File: tb/tb_pipe_ex.sv
// Directed bench for pipe_ex: expected EX/MEM contents queued at issue, popped after the edge.
module tb_pipe_ex;

  localparam int MD = 32;

  typedef struct packed {
    logic        wreg;
    logic        m2reg;
    logic        wmem;
    logic [4:0]  wn;
    logic [31:0] res;
    logic [31:0] di;
  } mem_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        EXwreg, EXm2reg, EXwmem, EXaluimm, EXshift;
  logic [4:0]  EXwn;
  logic [3:0]  EXaluc;
  logic [2:0]  EXmdop;
  logic [31:0] EXa, EXb, EXimm;
  logic        EXstall, MEMwreg, MEMm2reg, MEMwmem;
  logic [4:0]  MEMwn;
  logic [31:0] MEMaluResult, MEMdi;

  mem_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  pipe_ex #(.MD_CYCLES(MD)) dut (
    .clk(clk), .rst(rst),
    .EXwreg(EXwreg), .EXm2reg(EXm2reg), .EXwmem(EXwmem), .EXwn(EXwn),
    .EXaluc(EXaluc), .EXaluimm(EXaluimm), .EXshift(EXshift), .EXmdop(EXmdop),
    .EXa(EXa), .EXb(EXb), .EXimm(EXimm),
    .EXstall(EXstall),
    .MEMwreg(MEMwreg), .MEMm2reg(MEMm2reg), .MEMwmem(MEMwmem), .MEMwn(MEMwn),
    .MEMaluResult(MEMaluResult), .MEMdi(MEMdi)
  );

  task automatic chk_bit(input string tag, input logic got, input logic exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  task automatic chk_mem(input string tag, input mem_t exp);
    mem_t got;
    got = {MEMwreg, MEMm2reg, MEMwmem, MEMwn, MEMaluResult, MEMdi};
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got wreg=%b m2reg=%b wmem=%b wn=%0d res=%h di=%h expected wreg=%b m2reg=%b wmem=%b wn=%0d res=%h di=%h",
             tag, got.wreg, got.m2reg, got.wmem, got.wn, got.res, got.di,
             exp.wreg, exp.m2reg, exp.wmem, exp.wn, exp.res, exp.di);
    end
  endtask

  // Drive one instruction into EX for one cycle; a stalled slot must yield a bubble.
  task automatic issue(input string tag, input logic exp_stall, input logic [2:0] mdop,
                       input logic [3:0] aluc, input logic aluimm, input logic shift,
                       input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm,
                       input logic wreg, input logic m2reg, input logic wmem,
                       input logic [4:0] wn, input logic [31:0] exp_res);
    mem_t e;
    EXmdop = mdop; EXaluc = aluc; EXaluimm = aluimm; EXshift = shift;
    EXa = a; EXb = b; EXimm = imm;
    EXwreg = wreg; EXm2reg = m2reg; EXwmem = wmem; EXwn = wn;
    #1;
    chk_bit({tag, "_stall"}, EXstall, exp_stall);
    if (exp_stall) e = '0;
    else           e = '{wreg: wreg, m2reg: m2reg, wmem: wmem, wn: wn, res: exp_res, di: b};
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    chk_mem(tag, sb_q.pop_front());
  endtask

  task automatic nop(input string tag);
    issue(tag, 1'b0, 3'd0, 4'd0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
  endtask

  task automatic mf(input string tag, input logic exp_stall, input logic [2:0] mdop,
                    input logic [31:0] exp_res);
    issue(tag, exp_stall, mdop, 4'd0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0, 5'd8, exp_res);
  endtask

  initial begin
    // Reset with a live instruction in EX: outputs must still be cleared.
    rst = 1'b1;
    EXwreg = 1'b1; EXm2reg = 1'b1; EXwmem = 1'b1; EXwn = 5'd9;
    EXaluc = 4'd0; EXaluimm = 1'b0; EXshift = 1'b0; EXmdop = 3'd6;
    EXa = 32'h1; EXb = 32'h2; EXimm = 32'h0;
    @(posedge clk); @(posedge clk); #1;
    chk_mem("reset_mem", '0);
    chk_bit("reset_stall", EXstall, 1'b0);
    rst = 1'b0;

    // ALU sweep
    issue("add",  0, 0, 4'd0,  0, 0, 32'hFFFFFFF0, 32'h10, 0, 1, 0, 0, 5'd1, 32'h00000000);
    issue("sub",  0, 0, 4'd1,  0, 0, 32'hFFFFFFF0, 32'h10, 0, 1, 0, 0, 5'd2, 32'hFFFFFFE0);
    issue("and",  0, 0, 4'd2,  0, 0, 32'hFFFFFFF0, 32'h10, 0, 1, 0, 0, 5'd3, 32'h00000010);
    issue("or",   0, 0, 4'd3,  0, 0, 32'hFFFFFFF0, 32'h10, 0, 1, 0, 0, 5'd4, 32'hFFFFFFF0);
    issue("xor",  0, 0, 4'd4,  0, 0, 32'hFFFFFFF0, 32'h10, 0, 1, 0, 0, 5'd5, 32'hFFFFFFE0);
    issue("nor",  0, 0, 4'd11, 0, 0, 32'hFFFFFFF0, 32'h10, 0, 1, 0, 0, 5'd6, 32'h0000000F);
    issue("sltu", 0, 0, 4'd10, 0, 0, 32'hFFFFFFF0, 32'h10, 0, 1, 0, 0, 5'd7, 32'h00000000);
    issue("slt",  0, 0, 4'd9,  0, 0, 32'hFFFFFFF0, 32'h10, 0, 1, 0, 0, 5'd8, 32'h00000001);
    issue("sra",  0, 0, 4'd8,  0, 1, 32'h0, 32'h80000000, 32'h100, 1, 0, 0, 5'd9, 32'hF8000000);
    issue("srl",  0, 0, 4'd7,  0, 1, 32'h0, 32'h80000000, 32'h100, 1, 0, 0, 5'd10, 32'h08000000);
    issue("sll",  0, 0, 4'd6,  0, 1, 32'h0, 32'h10, 32'h100, 1, 0, 0, 5'd11, 32'h00000100);
    issue("lui",  0, 0, 4'd5,  1, 0, 32'hFFFFFFF0, 32'h10, 32'h1234, 1, 0, 0, 5'd12, 32'h12340000);
    issue("op13", 0, 0, 4'd13, 0, 0, 32'hFFFFFFF0, 32'h10, 0, 1, 0, 0, 5'd13, 32'h00000000);
    issue("load", 0, 0, 4'd0,  1, 0, 32'h100, 32'h10, 32'h4, 1, 1, 0, 5'd14, 32'h00000104);
    issue("store",0, 0, 4'd0,  1, 0, 32'h1000, 32'hDEADBEEF, 32'h20, 0, 0, 1, 5'd0, 32'h00001020);
    mf("mfhi_idle", 0, 3'd5, 32'h0);

    // mult -3 x 7, independent add during BUSY, then mflo stalls MD-1 cycles
    issue("mult", 0, 3'd1, 4'd0, 0, 0, 32'hFFFFFFFD, 32'h7, 0, 0, 0, 0, 5'd0, 32'h00000004);
    issue("add_busy", 0, 0, 4'd0, 0, 0, 32'h1, 32'h2, 0, 1, 0, 0, 5'd5, 32'h3);
    for (int i = 0; i < MD - 1; i++) mf("mflo_wait", 1, 3'd6, 32'h0);
    mf("mult_lo", 0, 3'd6, 32'hFFFFFFEB);
    mf("mult_hi", 0, 3'd5, 32'hFFFFFFFF);

    // div -7 / 2
    issue("div", 0, 3'd3, 4'd0, 0, 0, 32'hFFFFFFF9, 32'h2, 0, 0, 0, 0, 5'd0, 32'hFFFFFFFB);
    for (int i = 0; i < MD; i++) mf("div_wait", 1, 3'd6, 32'h0);
    mf("div_lo", 0, 3'd6, 32'hFFFFFFFD);
    mf("div_hi", 0, 3'd5, 32'hFFFFFFFF);

    // divu 7 / 0; the dependent carries a store, which must be bubbled while stalled
    issue("divu0", 0, 3'd4, 4'd0, 0, 0, 32'h7, 32'h0, 0, 0, 0, 0, 5'd0, 32'h7);
    for (int i = 0; i < MD; i++)
      issue("divu0_wait", 1, 3'd6, 4'd0, 0, 0, 32'h0, 32'hDEADBEEF, 0, 1, 0, 1, 5'd8, 32'h0);
    issue("divu0_lo", 0, 3'd6, 4'd0, 0, 0, 32'h0, 32'hDEADBEEF, 0, 1, 0, 1, 5'd8, 32'hFFFFFFFF);
    mf("divu0_hi", 0, 3'd5, 32'h7);

    // signed overflow divide
    issue("div_ovf", 0, 3'd3, 4'd0, 0, 0, 32'h80000000, 32'hFFFFFFFF, 0, 0, 0, 0, 5'd0, 32'h7FFFFFFF);
    for (int i = 0; i < MD; i++) mf("ovf_wait", 1, 3'd5, 32'h0);
    mf("ovf_hi", 0, 3'd5, 32'h0);
    mf("ovf_lo", 0, 3'd6, 32'h80000000);

    // mult then multu back-to-back: second waits for the first, then runs to completion
    issue("mult_a", 0, 3'd1, 4'd0, 0, 0, 32'h3, 32'h5, 0, 0, 0, 0, 5'd0, 32'h8);
    for (int i = 0; i < MD; i++)
      issue("multu_wait", 1, 3'd2, 4'd0, 0, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 0, 0, 5'd0, 32'h0);
    issue("multu_b", 0, 3'd2, 4'd0, 0, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 0, 0, 5'd0, 32'hFFFFFFFE);
    for (int i = 0; i < MD; i++) mf("multu_lo_wait", 1, 3'd6, 32'h0);
    mf("multu_lo", 0, 3'd6, 32'h00000001);
    mf("multu_hi", 0, 3'd5, 32'hFFFFFFFE);

    // reset in the middle of an operation (after 10 BUSY iterations)
    issue("mult_rst", 0, 3'd1, 4'd0, 0, 0, 32'h5, 32'h6, 0, 0, 0, 0, 5'd0, 32'hB);
    for (int i = 0; i < 10; i++) nop("busy_nop");
    rst = 1'b1;
    EXmdop = 3'd0; EXaluc = 4'd0; EXaluimm = 1'b0; EXshift = 1'b0;
    EXa = 32'h1; EXb = 32'h1; EXimm = 32'h0;
    EXwreg = 1'b1; EXm2reg = 1'b0; EXwmem = 1'b1; EXwn = 5'd3;
    @(posedge clk); #1;
    chk_mem("midrst_mem", '0);
    rst = 1'b0;
    mf("midrst_lo", 0, 3'd6, 32'h0);
    mf("midrst_hi", 0, 3'd5, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
